// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control FSM with a mem_ready handshake on fetch, load and store.
// Optional CTRL_PERF_EN adds a retired-instruction counter output (instret).
module mips_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic       illegal,
    output logic [3:0] state_o
`ifdef CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] instret
`endif
);

    // state  | meaning
    // FETCH  | read instruction at PC, PC += 4 when memory completes
    // DECODE | compute branch target, dispatch on opcode
    // MEMADR | effective address for lw/sw
    // MEMRD  | data read, wait for mem_ready
    // MEMWB  | load result into rt
    // MEMWR  | data write, strobe held until mem_ready
    // EXEC   | R-type ALU operation
    // ALUWB  | R-type result into rd
    // BEQ    | compare, take branch on zero
    // ADDIEX | rs + signext imm
    // ADDIWB | addi result into rt
    // JUMP   | load jump target
    // ILL    | unsupported opcode, flag and continue
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BEQ    = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11,
        ILL    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("CNT_W must be at least 1");
    end

    state_t state, next;
    logic   pcwrite, branch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= next;
    end

    always_comb begin
        next     = state;
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        aluop    = 2'b00;
        pcsrc    = 2'b00;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        illegal  = 1'b0;
        case (state)
            FETCH: begin
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcwrite = mem_ready;
                if (mem_ready) next = DECODE;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: next = MEMADR;
                    OP_RTYPE:     next = EXEC;
                    OP_BEQ:       next = BEQ;
                    OP_ADDI:      next = ADDIEX;
                    OP_J:         next = JUMP;
                    default:      next = ILL;
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                next    = (op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                iord = 1'b1;
                if (mem_ready) next = MEMWB;
            end
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
                next     = FETCH;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                if (mem_ready) next = FETCH;
            end
            EXEC: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                next    = ALUWB;
            end
            ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                next     = FETCH;
            end
            BEQ: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
                next    = FETCH;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                next    = ADDIWB;
            end
            ADDIWB: begin
                regwrite = 1'b1;
                next     = FETCH;
            end
            JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                next    = FETCH;
            end
            ILL: begin
                illegal = 1'b1;
                next    = FETCH;
            end
            default: next = FETCH;
        endcase
        // State is already FETCH under reset, but FETCH strobes follow mem_ready.
        if (reset) begin
            irwrite  = 1'b0;
            pcwrite  = 1'b0;
            branch   = 1'b0;
            memwrite = 1'b0;
            regwrite = 1'b0;
            illegal  = 1'b0;
        end
    end

    assign pcen    = pcwrite | (branch & zero);
    assign state_o = state;

`ifdef CTRL_PERF_EN
    logic retire;

    always_comb begin
        retire = 1'b0;
        case (state)
            MEMWB, ALUWB, BEQ, ADDIWB, JUMP: retire = 1'b1;
            MEMWR:                           retire = mem_ready;
            default:                         retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       instret <= '0;
        else if (retire) instret <= instret + CNT_W'(1);
    end
`endif

endmodule
